sorted_serializer_4: RTL and testbench
======================================

SORTED_SERIALIZER_4 -- requirements
Module: sorted_serializer_4

Interface
REQ-001 Parameter DATAWIDTH, default 8, bit width of one data element.
REQ-002 Parameter DATALENGTH, default 4, elements per sorted block; fixed at 4, other values unsupported.
REQ-003 Parameter DEPTH, default 2, block-buffer capacity in blocks; legal range 2..8.
REQ-004 clk_i  input  1  single clock, all state on rising edge.
REQ-005 rstn_i  input  1  reset, asynchronous, active-low.
REQ-006 in_valid_i  input  1  sorted block present on x_i, driven from the upstream sorter's output-valid control.
REQ-007 x_i  input  DATALENGTH x DATAWIDTH  sorted block; x_i[0] is the first element to emit.
REQ-008 in_ready_o  input-side  output  1  buffer can accept a block this cycle.
REQ-009 y_o  output  DATAWIDTH  current serial element.
REQ-010 out_valid_o  output  1  y_o holds a valid element.
REQ-011 out_ready_i  input  1  downstream accepts y_o this cycle.
REQ-012 out_idx_o  output  2  position (0..3) of y_o within its block.
REQ-013 out_last_o  output  1  y_o is element 3 of its block.
REQ-014 blk_cnt_o  output  $clog2(DEPTH+1)  blocks currently buffered, including a partially drained block.
REQ-015 overflow_o  output  1  sticky flag: a block was dropped.

Function
REQ-016 Storage: circular buffer of DEPTH block entries, write pointer, read pointer, and block count; pointers wrap from DEPTH-1 to 0.
REQ-017 in_ready_o: equals (blk_cnt_o < DEPTH) from registered state only, with no combinational path from out_ready_i.
REQ-018 Push: in_valid_i=1 and in_ready_o=1 at a rising edge writes all DATALENGTH elements into the write-pointer entry, advances the write pointer, and increments the count.
REQ-019 Drop: in_valid_i=1 and in_ready_o=0 discards the block, leaves all buffer state unchanged, and sets overflow_o to 1 until reset.
REQ-020 out_valid_o: equals (blk_cnt_o != 0).
REQ-021 y_o: entry[rd_ptr][elem_idx], where elem_idx is the internal 2-bit element counter; out_idx_o = elem_idx.
REQ-022 out_last_o: equals out_valid_o AND (elem_idx == 3).
REQ-023 Latency: a block pushed at edge N appears with out_valid_o=1 in the cycle after edge N, provided the buffer was empty; zero added bubbles.
REQ-024 Output handshake: an element transfers when out_valid_o=1 and out_ready_i=1.
REQ-025 Non-last transfer: elem_idx increments.
REQ-026 Last transfer (elem_idx=3): elem_idx wraps to 0, the read pointer advances, and the count decrements.
REQ-027 Stall: while out_valid_o=1 and out_ready_i=0, y_o, out_idx_o and out_last_o hold stable.
REQ-028 Simultaneous push and pop of the last element in one cycle: count is unchanged and both pointers advance.
REQ-029 Back-to-back throughput: a new block's element 0 is presented in the cycle immediately after the previous block's last transfer.
REQ-030 Data order: output order equals input index order; no re-sorting is performed.
REQ-031 Empty state: out_ready_i is ignored; elem_idx holds at 0.

Reset
REQ-032 rstn_i=0 asynchronously clears the following: pointers, count, elem_idx, overflow_o, out_valid_o (0), out_last_o (0), out_idx_o (0), blk_cnt_o (0), y_o (0). in_ready_o is 1.
REQ-033 Buffer data contents need not be reset.
REQ-034 Reset asserted mid-block abandons the partial block and all buffered blocks.
REQ-035 After rstn_i deasserts, the first rising edge with in_valid_i=1 performs a normal push.

Verification
REQ-036 Single block, out_ready_i=1 constant: push {3,7,9,200} -> y_o = 3,7,9,200 on 4 consecutive cycles; out_idx_o = 0..3; out_last_o only with 200; then out_valid_o=0.
REQ-037 Backpressure: push {1,2,3,4} and hold out_ready_i=0 for 5 cycles -> y_o=1, out_idx_o=0 stable throughout; after release, 1,2,3,4 are emitted.
REQ-038 Fill and overflow (DEPTH=2, out_ready_i=0): push 3 blocks on consecutive cycles -> in_ready_o=0 after the 2nd push; 3rd block is dropped; overflow_o=1; blk_cnt_o=2; draining yields blocks 1 and 2 only.
REQ-039 Streaming: a block is pushed every 4 cycles with out_ready_i=1 -> a continuous 1-element/cycle output with no gaps; simultaneous push/pop keeps blk_cnt_o=1.
REQ-040 Pointer wrap: push and drain 2*DEPTH+1 distinct blocks -> all elements emitted in order with no corruption across the pointer wrap.
REQ-041 Reset mid-drain: assert rstn_i low while out_idx_o=2 -> all outputs go to their reset values immediately, overflow_o clears, and the next pushed block starts at out_idx_o=0.

Source files
------------

// File: rtl/sorted_serializer_4.sv
// Buffers sorted 4-element blocks in a small circular queue and emits them one element per
// handshake, in input index order, with position and last-element markers.
module sorted_serializer_4 #(
  parameter int unsigned DATAWIDTH  = 8,
  parameter int unsigned DATALENGTH = 4,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                            clk_i,
  input  logic                            rstn_i,
  input  logic                            in_valid_i,
  input  logic [DATALENGTH*DATAWIDTH-1:0] x_i,
  output logic                            in_ready_o,
  output logic [DATAWIDTH-1:0]            y_o,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [1:0]                      out_idx_o,
  output logic                            out_last_o,
  output logic [$clog2(DEPTH+1)-1:0]      blk_cnt_o,
  output logic                            overflow_o
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned BlkW = DATALENGTH * DATAWIDTH;

  logic [BlkW-1:0] mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      elem_q, elem_d;
  logic            overflow_q, overflow_d;

  logic            push, pop_el, pop_blk;
  logic [BlkW-1:0] rd_blk;

  // Readiness depends only on the registered count, never on out_ready_i.
  assign in_ready_o  = (cnt_q < CntW'(DEPTH));
  assign out_valid_o = (cnt_q != '0);
  assign push        = in_valid_i & in_ready_o;
  assign pop_el      = out_valid_o & out_ready_i;
  assign pop_blk     = pop_el & (elem_q == 2'd3);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    elem_d     = elem_q;
    overflow_d = overflow_q | (in_valid_i & ~in_ready_o);

    if (push) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (pop_blk) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
    // 2-bit counter wraps 3 -> 0 on the last transfer by itself.
    if (pop_el) begin
      elem_d = elem_q + 2'd1;
    end

    if (push && !pop_blk) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (!push && pop_blk) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      elem_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      elem_q     <= elem_d;
      overflow_q <= overflow_d;
    end
  end

  // Block storage carries no reset; outputs are gated by out_valid_o instead.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= x_i;
    end
  end

  assign rd_blk = mem_q[rd_ptr_q];

  always_comb begin
    y_o = '0;
    if (out_valid_o) begin
      for (int i = 0; i < DATALENGTH; i++) begin
        if (elem_q == 2'(i)) begin
          y_o = rd_blk[i*DATAWIDTH +: DATAWIDTH];
        end
      end
    end
  end

  assign out_idx_o  = elem_q;
  assign out_last_o = out_valid_o & (elem_q == 2'd3);
  assign blk_cnt_o  = cnt_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_sorted_serializer_4.sv
// Scoreboard bench for sorted_serializer_4: stimulus queues expected elements, a negedge
// monitor pops and compares on every output handshake.
module tb_sorted_serializer_4;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic [31:0] x;
  logic        in_ready;
  logic [7:0]  y;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  idx;
  logic        last;
  logic [1:0]  blk_cnt;
  logic        overflow;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [10:0] exp_q[$];
  logic [10:0] mon_e;

  sorted_serializer_4 #(
    .DATAWIDTH (8),
    .DATALENGTH(4),
    .DEPTH     (2)
  ) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .in_valid_i (in_valid),
    .x_i        (x),
    .in_ready_o (in_ready),
    .y_o        (y),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_idx_o  (idx),
    .out_last_o (last),
    .blk_cnt_o  (blk_cnt),
    .overflow_o (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  // Monitor: every accepted output element must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got y=%0d idx=%0d last=%0d, expected no output",
                 y, idx, last);
      end else begin
        mon_e = exp_q.pop_front();
        if ({y, idx, last} !== mon_e) begin
          errors++;
          $display("FAIL stream: got y=%0d idx=%0d last=%0d, expected y=%0d idx=%0d last=%0d",
                   y, idx, last, mon_e[10:3], mon_e[2:1], mon_e[0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_blk(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                          input logic [7:0] d, input logic accept);
    x        = {d, c, b, a};
    in_valid = 1'b1;
    chk("in_ready_at_push", 32'(in_ready), 32'(accept));
    if (accept) begin
      exp_q.push_back({a, 2'd0, 1'b0});
      exp_q.push_back({b, 2'd1, 1'b0});
      exp_q.push_back({c, 2'd2, 1'b0});
      exp_q.push_back({d, 2'd3, 1'b1});
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && (exp_q.size() != 0 || out_valid); i++) tick();
    chk("drain_done", {31'(exp_q.size()), out_valid}, 32'd0);
  endtask

  task automatic chk_reset_outs(input string name);
    chk({name, "_valid"}, 32'(out_valid), 32'd0);
    chk({name, "_y"}, 32'(y), 32'd0);
    chk({name, "_idx"}, 32'(idx), 32'd0);
    chk({name, "_last"}, 32'(last), 32'd0);
    chk({name, "_cnt"}, 32'(blk_cnt), 32'd0);
    chk({name, "_ovf"}, 32'(overflow), 32'd0);
    chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rstn      = 1'b0;
    in_valid  = 1'b0;
    x         = '0;
    out_ready = 1'b0;
    #2;
    chk_reset_outs("rst");
    #10;
    rstn = 1'b1;
    tick();

    // Single block, constant ready: four consecutive elements then idle.
    out_ready = 1'b1;
    push_blk(8'd3, 8'd7, 8'd9, 8'd200, 1'b1);
    chk("single_latency_valid", 32'(out_valid), 32'd1);
    chk("single_first_y", 32'(y), 32'd3);
    repeat (4) tick();
    chk("single_done_valid", 32'(out_valid), 32'd0);
    chk("single_done_q", 32'(exp_q.size()), 32'd0);

    // Backpressure: output holds for five stalled cycles.
    out_ready = 1'b0;
    push_blk(8'd1, 8'd2, 8'd3, 8'd4, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("stall_y", 32'(y), 32'd1);
      chk("stall_idx", 32'(idx), 32'd0);
      chk("stall_last", 32'(last), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    wait_drain();

    // Fill and overflow: third block dropped.
    out_ready = 1'b0;
    push_blk(8'd11, 8'd12, 8'd13, 8'd14, 1'b1);
    push_blk(8'd21, 8'd22, 8'd23, 8'd24, 1'b1);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    push_blk(8'd31, 8'd32, 8'd33, 8'd34, 1'b0);
    chk("overflow_set", 32'(overflow), 32'd1);
    chk("full_cnt", 32'(blk_cnt), 32'd2);
    out_ready = 1'b1;
    wait_drain();
    chk("overflow_sticky", 32'(overflow), 32'd1);

    // Streaming: push every 4 cycles; output must be gap-free.
    for (int k = 0; k < 4; k++) begin
      push_blk(8'(40 + 4 * k), 8'(41 + 4 * k), 8'(42 + 4 * k), 8'(43 + 4 * k), 1'b1);
      chk("stream_cnt", 32'(blk_cnt), 32'd1);
      chk("stream_valid", 32'(out_valid), 32'd1);
      if (k < 3) repeat (3) tick();
    end
    repeat (4) tick();
    chk("stream_no_gap_q", 32'(exp_q.size()), 32'd0);
    chk("stream_end_valid", 32'(out_valid), 32'd0);

    // Pointer wrap: five distinct blocks through a two-entry buffer.
    for (int k = 0; k < 5; k++) begin
      push_blk(8'(100 + 4 * k), 8'(101 + 4 * k), 8'(102 + 4 * k), 8'(103 + 4 * k), 1'b1);
      if (k % 2 == 1 || k == 4) wait_drain();
    end

    // Reset mid-drain at element 2.
    push_blk(8'd10, 8'd20, 8'd30, 8'd40, 1'b1);
    tick();
    tick();
    chk("middrain_idx", 32'(idx), 32'd2);
    #1;
    rstn = 1'b0;
    exp_q.delete();
    #1;
    chk_reset_outs("middrain_rst");
    #2;
    rstn = 1'b1;
    tick();
    push_blk(8'd5, 8'd6, 8'd7, 8'd8, 1'b1);
    chk("post_rst_idx", 32'(idx), 32'd0);
    chk("post_rst_y", 32'(y), 32'd5);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
